cp_insert: RTL and testbench
============================

Name: cp_insert

Overview:
- Parametrised cyclic-prefix inserter for the OFDM transmit chain; sits between the IFFT output and the DAC/framing stage.
- Buffers one full OFDM symbol of N complex samples.
- Emits the last Tg samples (the prefix), then the whole symbol, on a valid/ready stream.
- Tg is runtime-selectable among the WiMAX ratios N/4, N/8, N/16, N/32, plus a bypass mode with no prefix.

Parameters:
- num_sz, 16, bits per I or Q component; a sample is 2*num_sz bits, I in the upper half.
- fft_n, 256, symbol length N in samples; power of two, 64..2048.
- aw, clog2(fft_n), address and counter width, derived.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture param_Tg into the pending-ratio register.
- param_Tg  in  3  prefix select: 0=N/4, 1=N/8, 2=N/16, 3=N/32, 4..7=bypass (Tg=0).
- in_data  in  2*num_sz  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts an input sample this cycle.
- out_data  out  2*num_sz  output sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sop  out  1  first sample of an output burst (first prefix sample, or first body sample in bypass).
- out_eop  out  1  last body sample of the burst.
- out_cp  out  1  current output sample is a prefix sample.

Behaviour:
- Reset, active on any cycle and in any state:
  - state <= FILL; wr_cnt, rd_cnt, pend_valid <= 0.
  - out_valid, out_sop, out_eop, out_cp <= 0; out_data <= 0.
  - tg_sel and pend_sel <= param_Tg, sampled on the reset cycle.
  - in_ready is 0 during the reset cycle and 1 on the first cycle after reset deasserts.
  - Any partially filled or partially drained symbol is discarded.
- Handshakes:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_sop, out_eop and out_cp hold stable.
- Tg derivation: tg = fft_n >> (2 + tg_sel) for tg_sel 0..3, else 0. All arithmetic is unsigned aw-bit; prefix start address = fft_n - tg, modulo fft_n.
- Parameter update:
  - load=1 sets pend_sel <= param_Tg and pend_valid <= 1 in any state; a second load overwrites the first.
  - On the transition into PREFIX, if pend_valid: tg_sel <= pend_sel, pend_valid <= 0.
  - tg never changes mid-symbol.
  - load on the same cycle as that transition is not applied to that symbol; it applies to the next one.
- Buffer: single-port-style RAM, fft_n x 2*num_sz, 1-cycle read latency, plus a 1-entry output register and a 1-entry prefetch register so reads stream without bubbles.
- FSM:
  - FILL: in_ready=1. Each input transfer writes RAM[wr_cnt] and increments wr_cnt. On the transfer with wr_cnt = fft_n-1: wr_cnt <= 0, in_ready drops next cycle, go to PREFIX (tg>0) or BODY (tg=0).
  - PREFIX: in_ready=0. Read addresses fft_n-tg .. fft_n-1 in order, out_cp=1. The first sample has out_sop=1. After the transfer of the last prefix sample, go to BODY.
  - BODY: in_ready=0. Read addresses 0 .. fft_n-1, out_cp=0. out_sop=1 on address 0 only when tg=0. out_eop=1 on address fft_n-1. After the out_eop transfer, go to FILL; in_ready=1 on the following cycle.
- Timing:
  - First out_valid is asserted 2 cycles after the last input transfer.
  - With out_ready held high, one sample per cycle: burst length fft_n+tg cycles with no gaps.
  - The PREFIX->BODY boundary is seamless (no bubble).
- Backpressure: out_ready low for any duration stalls the read pointer; no sample is dropped or duplicated.
- Inputs are ignored when in_ready=0. in_valid low during FILL simply pauses the fill.
- Throughput: per symbol, fft_n input cycles plus fft_n+tg output cycles; no overlap (not pipelined).

Test Plan:
- fft_n=64, param_Tg=0 at reset, in_data = sample index 0..63 with continuous valid and out_ready=1 -> out_data 48..63 (out_cp=1, sop on 48), then 0..63 (eop on 63); 80 consecutive out_valid cycles; in_ready=0 from the cycle after input 63 until the cycle after the eop transfer.
- fft_n=64, param_Tg=3 -> prefix 62,63 then 0..63. Then param_Tg=5 with load=1 during BODY -> next symbol outputs 0..63 with sop on 0 and out_cp never asserted.
- Random out_ready (50%) and random in_valid gaps, three symbols with tg_sel=1 -> each burst is exactly the 8 prefix samples (56..63) then 0..63, in order, no drops or duplicates; outputs stable while stalled.
- load with param_Tg=2 on the exact cycle of the FILL->PREFIX transition, previous sel=0 -> current symbol uses 16 prefix samples, next symbol uses 4.
- reset asserted mid-PREFIX (after 5 outputs) -> out_valid=0 the next cycle; in_ready=1 one cycle after reset deasserts; the following symbol is output complete and correct.
- fft_n=2048, tg_sel=0 -> 512 prefix samples starting at address 1536; address wrap to 0 at the BODY start is correct.

Source files
------------

// File: rtl/cp_insert.sv
`default_nettype none
// ============================================================================
// Module   : cp_insert
// Brief    : OFDM cyclic-prefix inserter. Buffers one symbol, then replays its
//            tail as the prefix followed by the full symbol.
// Revision : 1.0
// ============================================================================
module cp_insert #(
  parameter int NUM_SZ = 16,
  parameter int FFT_N  = 256,
  parameter int AW     = $clog2(FFT_N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [2:0]          param_Tg,
  input  logic [2*NUM_SZ-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*NUM_SZ-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic                out_cp
);

  localparam int DW = 2 * NUM_SZ;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  function automatic logic [AW-1:0] tg_of(input logic [2:0] sel);
    logic [AW-1:0] tg;
    tg = '0;
    if (!sel[2]) tg = AW'(FFT_N >> (2 + int'(sel[1:0])));
    return tg;
  endfunction

  // Control state
  state_t        state_q;
  logic [AW-1:0] wr_cnt_q;
  logic [AW-1:0] rd_cnt_q;
  logic          rd_done_q;
  logic [2:0]    tg_sel_q;
  logic [2:0]    pend_sel_q;
  logic          pend_valid_q;

  // Read pipeline: RAM read stage, prefetch slot, output slot. Flags are {sop, eop, cp}.
  logic [DW-1:0] mem [FFT_N];
  logic [DW-1:0] mem_rd_q;
  logic          rd_vld_q;
  logic [2:0]    rd_flag_q;
  logic          pf_valid_q;
  logic [DW-1:0] pf_data_q;
  logic [2:0]    pf_flag_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [2:0]    out_flag_q;

  logic [AW-1:0] w_tg;
  logic [AW-1:0] w_pfx_base;
  logic [AW-1:0] w_rd_addr;
  logic [2:0]    w_next_sel;
  logic [2:0]    w_occ;
  logic [2:0]    w_issue_flag;
  logic          w_in_xfer;
  logic          w_last_in;
  logic          w_pop;
  logic          w_issue;
  logic          w_last_pfx;
  logic          w_last_body;

  assign in_ready  = (state_q == ST_FILL) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_flag_q[2];
  assign out_eop   = out_flag_q[1];
  assign out_cp    = out_flag_q[0];

  assign w_tg        = tg_of(tg_sel_q);
  assign w_pfx_base  = '0 - w_tg;
  assign w_next_sel  = pend_valid_q ? pend_sel_q : tg_sel_q;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_last_in   = w_in_xfer && (wr_cnt_q == AW'(FFT_N - 1));
  assign w_pop       = out_valid_q && out_ready;
  assign w_last_pfx  = (rd_cnt_q == w_tg - AW'(1));
  assign w_last_body = (rd_cnt_q == AW'(FFT_N - 1));

  // A read may issue only if its data is guaranteed a free slot when it lands.
  assign w_occ   = 3'(out_valid_q) + 3'(pf_valid_q) + 3'(rd_vld_q) - 3'(w_pop);
  assign w_issue = (state_q != ST_FILL) && !rd_done_q && (w_occ <= 3'd1);

  always_comb begin
    w_rd_addr    = rd_cnt_q;
    w_issue_flag = 3'b000;
    if (state_q == ST_PREFIX) begin
      w_rd_addr    = w_pfx_base + rd_cnt_q;
      w_issue_flag = {rd_cnt_q == '0, 1'b0, 1'b1};
    end else begin
      w_issue_flag = {(rd_cnt_q == '0) && (w_tg == '0), w_last_body, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) mem[wr_cnt_q] <= in_data;
    if (w_issue)   mem_rd_q      <= mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      rd_done_q    <= 1'b0;
      tg_sel_q     <= param_Tg;
      pend_sel_q   <= param_Tg;
      pend_valid_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_flag_q    <= 3'b000;
    end else begin
      if (load) begin
        pend_sel_q   <= param_Tg;
        pend_valid_q <= 1'b1;
      end
      rd_vld_q <= w_issue;
      if (w_issue) rd_flag_q <= w_issue_flag;

      case (state_q)
        ST_FILL: begin
          if (w_in_xfer) wr_cnt_q <= wr_cnt_q + AW'(1);
          if (w_last_in) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
            // The ratio is latched here; a load on this very cycle stays pending.
            if (pend_valid_q) begin
              tg_sel_q     <= pend_sel_q;
              pend_valid_q <= load;
            end
            state_q <= (tg_of(w_next_sel) != '0) ? ST_PREFIX : ST_BODY;
          end
        end
        ST_PREFIX: begin
          if (w_issue) begin
            if (w_last_pfx) begin
              rd_cnt_q <= '0;
              state_q  <= ST_BODY;
            end else begin
              rd_cnt_q <= rd_cnt_q + AW'(1);
            end
          end
        end
        ST_BODY: begin
          if (w_issue) begin
            if (w_last_body) rd_done_q <= 1'b1;
            else             rd_cnt_q  <= rd_cnt_q + AW'(1);
          end
          if (w_pop && out_flag_q[1]) begin
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
            state_q   <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flag_q  <= 3'b000;
      pf_valid_q  <= 1'b0;
    end else if (w_pop || !out_valid_q) begin
      if (pf_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pf_data_q;
        out_flag_q  <= pf_flag_q;
        pf_valid_q  <= rd_vld_q;
        if (rd_vld_q) begin
          pf_data_q <= mem_rd_q;
          pf_flag_q <= rd_flag_q;
        end
      end else if (rd_vld_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_rd_q;
        out_flag_q  <= rd_flag_q;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (rd_vld_q) begin
      pf_valid_q <= 1'b1;
      pf_data_q  <= mem_rd_q;
      pf_flag_q  <= rd_flag_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp_insert.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp_insert
// Brief    : Scoreboard bench for cp_insert; a 64-point and a 2048-point
//            instance share clock and reset.
// Revision : 1.0
// ============================================================================
module tb_cp_insert;

  logic        clk;
  logic        reset;
  logic        load      [2];
  logic [2:0]  param_Tg  [2];
  logic [31:0] in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_sop   [2];
  logic        out_eop   [2];
  logic        out_cp    [2];

  int checks   = 0;
  int failures = 0;

  logic [34:0] sb0 [$];
  logic [34:0] sb1 [$];
  logic        mon_en     [2];
  logic        rdy_rand   [2];
  logic        prev_stall [2];
  logic [34:0] prev_obs   [2];
  int          xcnt       [2];
  int          sym_base = 0;

  cp_insert #(.NUM_SZ(16), .FFT_N(64)) u_dut64 (
    .clk(clk), .reset(reset), .load(load[0]), .param_Tg(param_Tg[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sop(out_sop[0]), .out_eop(out_eop[0]), .out_cp(out_cp[0])
  );

  cp_insert #(.NUM_SZ(16), .FFT_N(2048)) u_dut2k (
    .clk(clk), .reset(reset), .load(load[1]), .param_Tg(param_Tg[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sop(out_sop[1]), .out_eop(out_eop[1]), .out_cp(out_cp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int nof(input int j);
    return (j == 0) ? 64 : 2048;
  endfunction

  function automatic logic [31:0] mk(input int base, input int i);
    logic [15:0] v;
    v = 16'(base + i);
    return {v, ~v};
  endfunction

  function automatic logic [34:0] pack_obs(input int j);
    return {out_data[j], out_sop[j], out_eop[j], out_cp[j]};
  endfunction

  function automatic int sb_size(input int j);
    return (j == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [34:0] sb_pop(input int j);
    if (j == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int j, input int tg, input int base);
    int n;
    logic [34:0] e;
    n = nof(j);
    for (int k = 0; k < tg; k++) begin
      e = {mk(base, n - tg + k), k == 0, 1'b0, 1'b1};
      if (j == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e = {mk(base, i), (i == 0) && (tg == 0), i == n - 1, 1'b0};
      if (j == 0) sb0.push_back(e); else sb1.push_back(e);
    end
  endtask

  task automatic pulse_load(input int j, input logic [2:0] v);
    load[j]     = 1'b1;
    param_Tg[j] = v;
    tick();
    load[j]     = 1'b0;
  endtask

  // Feeds one symbol; optional load on the cycle of the final input transfer.
  task automatic send_symbol(input int j, input int tg, input bit push, input bit gaps,
                             input bit ld_last, input logic [2:0] ld_val);
    int n;
    int g;
    n = nof(j);
    sym_base = sym_base + 4096;
    if (push) push_exp(j, tg, sym_base);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid[j] = 1'b0;
          tick();
        end
      end
      in_valid[j] = 1'b1;
      in_data[j]  = mk(sym_base, i);
      g = 0;
      while (!in_ready[j] && g < 6000) begin
        tick();
        g++;
      end
      if (g >= 6000) check("in_ready_wait", 64'(in_ready[j]), 64'd1);
      if (ld_last && i == n - 1) begin
        load[j]     = 1'b1;
        param_Tg[j] = ld_val;
      end
      tick();
      load[j] = 1'b0;
    end
    in_valid[j] = 1'b0;
  endtask

  task automatic wait_drain(input int j, input int limit, input string tag);
    int g;
    g = 0;
    while ((sb_size(j) != 0 || out_valid[j]) && g < limit) begin
      tick();
      g++;
    end
    check(tag, {31'd0, 32'(sb_size(j)), out_valid[j]}, 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 2; j++)
      out_ready[j] = rdy_rand[j] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        prev_stall[j] <= 1'b0;
      end else begin
        if (prev_stall[j] && mon_en[j])
          check("stall_hold", {28'd0, out_valid[j], pack_obs(j)}, {28'd0, 1'b1, prev_obs[j]});
        if (out_valid[j] && out_ready[j]) begin
          xcnt[j] <= xcnt[j] + 1;
          if (mon_en[j]) begin
            if (sb_size(j) == 0) check("unexpected_out", 64'(out_valid[j]), 64'd0);
            else check((j == 0) ? "out64" : "out2k", 64'(pack_obs(j)), 64'(sb_pop(j)));
          end
        end
        prev_stall[j] <= out_valid[j] && !out_ready[j];
        prev_obs[j]   <= pack_obs(j);
      end
    end
  end

  initial begin
    int cnt;
    int g;
    int start;
    bit ir_low;
    for (int j = 0; j < 2; j++) begin
      load[j] = 1'b0; param_Tg[j] = 3'd0; in_data[j] = '0; in_valid[j] = 1'b0;
      mon_en[j] = 1'b1; rdy_rand[j] = 1'b0; xcnt[j] = 0; prev_stall[j] = 1'b0; prev_obs[j] = '0;
    end
    reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready64", 64'(in_ready[0]), 64'd0);
    check("rst_out_valid64", 64'(out_valid[0]), 64'd0);
    check("rst_out_data64", 64'(out_data[0]), 64'd0);
    check("rst_out_valid2k", 64'(out_valid[1]), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Symbol with N/4 prefix: latency, burst length and in_ready window
    send_symbol(0, 16, 1'b1, 1'b0, 1'b0, 3'd0);
    check("ready_drop", 64'(in_ready[0]), 64'd0);
    tick();
    check("lat1_valid", 64'(out_valid[0]), 64'd0);
    tick();
    check("lat2_valid", 64'(out_valid[0]), 64'd1);
    cnt = 0;
    ir_low = 1'b1;
    while (out_valid[0] && cnt < 200) begin
      if (in_ready[0]) ir_low = 1'b0;
      cnt++;
      tick();
    end
    check("burst_len", 64'(cnt), 64'd80);
    check("ready_low_burst", 64'(ir_low), 64'd1);
    check("ready_after_eop", 64'(in_ready[0]), 64'd1);
    wait_drain(0, 200, "drain_t1");

    // N/32 prefix, then bypass loaded mid-BODY
    pulse_load(0, 3'd3);
    send_symbol(0, 2, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (10) tick();
    pulse_load(0, 3'd5);
    wait_drain(0, 300, "drain_t2a");
    send_symbol(0, 0, 1'b1, 1'b0, 1'b0, 3'd0);
    wait_drain(0, 300, "drain_t2b");

    // Random backpressure and input gaps, three N/8 symbols
    pulse_load(0, 3'd1);
    rdy_rand[0] = 1'b1;
    for (int s = 0; s < 3; s++) send_symbol(0, 8, 1'b1, 1'b1, 1'b0, 3'd0);
    wait_drain(0, 3000, "drain_t3");
    rdy_rand[0] = 1'b0;
    tick();

    // Load coinciding with the FILL->PREFIX transition
    pulse_load(0, 3'd0);
    send_symbol(0, 16, 1'b1, 1'b0, 1'b1, 3'd2);
    send_symbol(0, 4, 1'b1, 1'b0, 1'b0, 3'd0);
    wait_drain(0, 400, "drain_t4");

    // Reset mid-PREFIX after five outputs
    pulse_load(0, 3'd0);
    mon_en[0] = 1'b0;
    start = xcnt[0];
    send_symbol(0, 16, 1'b0, 1'b0, 1'b0, 3'd0);
    g = 0;
    while (xcnt[0] < start + 5 && g < 200) begin
      tick();
      g++;
    end
    check("pre_reset_outs", 64'(xcnt[0] - start), 64'd5);
    check("pre_reset_cp", 64'(out_cp[0]), 64'd1);
    reset = 1'b1;
    param_Tg[0] = 3'd3;
    tick();
    check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    check("mid_rst_ready", 64'(in_ready[0]), 64'd0);
    reset = 1'b0;
    #1;
    check("rel_rst_ready", 64'(in_ready[0]), 64'd1);
    mon_en[0] = 1'b1;
    tick();
    send_symbol(0, 2, 1'b1, 1'b0, 1'b0, 3'd0);
    wait_drain(0, 300, "drain_t5");

    // 2048-point instance, N/4 prefix starting at address 1536
    send_symbol(1, 512, 1'b1, 1'b0, 1'b0, 3'd0);
    wait_drain(1, 4000, "drain_t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
